param_bank: RTL and testbench
=============================

Name: param_bank

Overview:
- Downstream consumer of the UART packet interface's byte stream: `update_reg` + `idx` + `read_data`, then a one-cycle `pc_ready`.
- Each byte is captured into a shadow register bank.
- The shadow is committed to an active bank on a frame boundary, so the renderer never sees a half-updated packet.
- The active bank drives the GPU's scene/transform parameters as a flattened bus.

Parameters:
- NUM_REGS, 55, number of byte registers; legal idx range is 0..NUM_REGS-1.
- IDX_W, 6, width of idx; must satisfy 2^IDX_W >= NUM_REGS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- update_reg  in  1  one-cycle strobe: write read_data to shadow[idx].
- idx  in  IDX_W  byte index for update_reg.
- read_data  in  8  byte value.
- pc_ready  in  1  one-cycle packet-complete strobe.
- frame_start  in  1  one-cycle strobe at vblank start, from display timing.
- params  out  NUM_REGS*8  active bank, flattened; byte k at [8k+7:8k].
- commit_pending  out  1  packet complete, waiting for frame_start.
- commit_done  out  1  one-cycle pulse after the active bank changes.
- commit_cnt  out  8  number of commits, wraps 255->0.
- idx_err  out  1  sticky: update_reg arrived with idx >= NUM_REGS.

Behaviour:
- Reset (async, active-high): shadow, active (params), mask, commit_cnt all 0; commit_pending=0, commit_done=0, idx_err=0; state=IDLE.
- Write path:
  - update_reg sampled on edge E with idx<NUM_REGS: shadow[idx]<=read_data and mask[idx]<=1 at E.
  - idx>=NUM_REGS: write dropped, idx_err<=1 (cleared only by reset).
  - Writes are accepted in every state.
- State IDLE:
  - pc_ready -> PENDING, commit_pending=1 on the next cycle.
  - frame_start is ignored.
- State PENDING:
  - frame_start -> COMMIT action at that edge.
  - Every k with mask[k]=1 gets active[k]<=shadow[k]; unmasked bytes hold their old value.
  - mask<=0, commit_cnt<=commit_cnt+1, commit_done<=1 for one cycle, commit_pending<=0, state<=IDLE.
  - params reflects the new values in the cycle after the frame_start edge, together with commit_done.
  - A further pc_ready in PENDING is absorbed: stays PENDING, no second commit.
- Simultaneous events:
  - update_reg and frame_start on the same edge in PENDING: the commit uses shadow/mask before that write. The new byte lands in shadow with its mask bit set after the clear, so it goes to the next commit.
  - pc_ready and frame_start on the same edge in IDLE: enter PENDING; commit at the next frame_start.
- Empty commit (mask=0): commit still happens; params unchanged, commit_done pulses, commit_cnt increments.
- Reset mid-PENDING: everything returns to reset values; the pending packet is lost.
- commit_done is a registered output, never combinational.

Optional Feature:
- Macro PARAM_BANK_FRAME_SYNC_EN.
- Defined: commit waits in PENDING for frame_start, as above.
- Undefined:
  - frame_start is ignored.
  - pc_ready commits directly at its own sampling edge, with the same masking/counter/pulse rules; commit_pending stays 0.
  - update_reg on the same edge as pc_ready is not included in that commit.

Decomposition:
- Shared package `gpu_pkg`:
  - NUM_REGS default and IDX_W.
  - State enum {IDLE, PENDING}.
  - Named byte-index constants for GPU parameters (e.g. IDX_MODE=0, IDX_ROT_X=1, IDX_ROT_Y=2, IDX_CTRL=54).
- One natural sub-module, `param_byte_cell`: one shadow byte, one active byte and one mask bit, with write-enable, commit and clear inputs; generate NUM_REGS instances.
- The FSM, counter and error flag stay in the top module.

Test Plan:
- Reset mid-PENDING: write idx1=0x5A, pc_ready, assert reset before frame_start -> all outputs 0, commit_cnt=0, frame_start after release produces no commit.
- Basic commit: write idx0=0x11, idx1=0x22, idx2=0x33, idx54=0x44, pc_ready, frame_start 100 cycles later:
  - before frame_start, params all 0 and commit_pending=1;
  - cycle after frame_start, bytes 0,1,2,54 equal 0x11/0x22/0x33/0x44, others 0, commit_done high for exactly 1 cycle, commit_cnt=1.
- Partial update retention: after the basic commit, write only idx1=0x99, pc_ready, frame_start -> byte1=0x99, bytes 0,2,54 unchanged, commit_cnt=2.
- Collision: in PENDING, drive update_reg idx2=0x77 on the same edge as frame_start -> byte2 keeps its old value; next pc_ready+frame_start yields byte2=0x77.
- Bad index: update_reg idx=60 data 0xFF -> idx_err=1 and sticky, params and mask unchanged; frame_start while IDLE -> no commit.
- Macro undefined: write idx0=0xAB, pc_ready -> byte0=0xAB and commit_done pulse on the next cycle, no frame_start needed, commit_pending never 1.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU parameter-bank definitions: default bank geometry, the commit
// state encoding and named byte positions of the scene/transform parameters.
package gpu_pkg;

    // Default bank geometry; 2**DEFAULT_IDX_W must cover DEFAULT_NUM_REGS
    localparam int DEFAULT_NUM_REGS = 55;
    localparam int DEFAULT_IDX_W    = 6;

    // Commit state: IDLE collects bytes, PENDING holds a complete packet
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } bank_state_t;

    // Named byte positions inside the flattened parameter bus
    localparam int IDX_MODE    = 0;
    localparam int IDX_ROT_X   = 1;
    localparam int IDX_ROT_Y   = 2;
    localparam int IDX_ROT_Z   = 3;
    localparam int IDX_SCALE   = 4;
    localparam int IDX_TRANS_X = 5;
    localparam int IDX_TRANS_Y = 6;
    localparam int IDX_TRANS_Z = 7;
    localparam int IDX_CTRL    = 54;

    // True when a byte index addresses a real register of the bank
    function automatic logic idx_in_range(input int unsigned idx_value,
                                          input int unsigned num_regs);
        return idx_value < num_regs;
    endfunction

endpackage

// File: rtl/param_byte_cell.sv
// One byte of the parameter bank: a shadow byte that collects packet data,
// the active byte seen by the renderer, and a mask bit marking the shadow
// byte as written since the last commit.
module param_byte_cell (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       clear,
    output logic [7:0] active_byte
);

    logic [7:0] shadow_byte;
    logic       mask_bit;

    // Commit copies shadow to active only for written bytes; a write on the
    // commit edge lands after the mask clear so it belongs to the next commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_byte <= 8'h00;
            active_byte <= 8'h00;
            mask_bit    <= 1'b0;
        end else begin
            if (commit && mask_bit) begin
                active_byte <= shadow_byte;
            end
            if (wr_en) begin
                shadow_byte <= wr_data;
                mask_bit    <= 1'b1;
            end else if (clear) begin
                mask_bit    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_bank.sv
// Double-buffered GPU parameter bank. Bytes from the packet interface are
// collected in a shadow bank and copied to the active bank in one step, so
// the renderer never sees a half-updated packet.
//
// Build option PARAM_BANK_FRAME_SYNC_EN:
//   defined   - a completed packet waits in PENDING and commits on the next
//               frame_start (vblank), so parameters change between frames.
//   undefined - frame_start is ignored and pc_ready commits at its own edge;
//               commit_pending never rises.
module param_bank
    import gpu_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDX_W    = DEFAULT_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  update_reg,
    input  logic [IDX_W-1:0]      idx,
    input  logic [7:0]            read_data,
    input  logic                  pc_ready,
    input  logic                  frame_start,
    output logic [NUM_REGS*8-1:0] params,
    output logic                  commit_pending,
    output logic                  commit_done,
    output logic [7:0]            commit_cnt,
    output logic                  idx_err
);

    bank_state_t state;
    logic        idx_valid;
    logic        commit_fire;

    assign idx_valid = idx_in_range(32'(idx), NUM_REGS);

`ifdef PARAM_BANK_FRAME_SYNC_EN
    // The commit waits for vblank once a packet is complete
    assign commit_fire = (state == PENDING) && frame_start;
`else
    // The commit follows the packet-complete strobe directly
    assign commit_fire = pc_ready;
`endif

    // Commit sequencing, commit counter, done pulse and sticky index error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            commit_cnt     <= 8'h00;
            idx_err        <= 1'b0;
        end else begin
            commit_done <= commit_fire;
            if (commit_fire) begin
                commit_cnt <= commit_cnt + 8'd1;
            end
            if (update_reg && !idx_valid) begin
                idx_err <= 1'b1;
            end
            case (state)
                IDLE: begin
`ifdef PARAM_BANK_FRAME_SYNC_EN
                    if (pc_ready) begin
                        state          <= PENDING;
                        commit_pending <= 1'b1;
                    end
`endif
                end
                PENDING: begin
                    if (frame_start) begin
                        state          <= IDLE;
                        commit_pending <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    commit_pending <= 1'b0;
                end
            endcase
        end
    end

    // One cell per register; each decodes its own write strobe from idx
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        logic cell_wr;
        assign cell_wr = update_reg && (idx == IDX_W'(k));

        param_byte_cell u_cell (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (cell_wr),
            .wr_data     (read_data),
            .commit      (commit_fire),
            .clear       (commit_fire),
            .active_byte (params[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_param_bank.sv
// Scoreboard bench for param_bank. A behavioural model of the bank (byte
// arrays and a pending flag) predicts every commit; each predicted commit is
// queued and a negedge monitor pops it when commit_done appears.
module tb_param_bank;
    import gpu_pkg::*;

    localparam int NREG = DEFAULT_NUM_REGS;
    localparam int IW   = DEFAULT_IDX_W;
    localparam int PW   = NREG * 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          update_reg = 1'b0;
    logic [IW-1:0] idx = '0;
    logic [7:0]    read_data = 8'h00;
    logic          pc_ready = 1'b0;
    logic          frame_start = 1'b0;
    logic [PW-1:0] params;
    logic          commit_pending;
    logic          commit_done;
    logic [7:0]    commit_cnt;
    logic          idx_err;

    param_bank dut (
        .clk            (clk),
        .reset          (reset),
        .update_reg     (update_reg),
        .idx            (idx),
        .read_data      (read_data),
        .pc_ready       (pc_ready),
        .frame_start    (frame_start),
        .params         (params),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .commit_cnt     (commit_cnt),
        .idx_err        (idx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] bank;
        logic [7:0]    cnt;
    } commit_t;

    commit_t    exp_q[$];

    // Reference model state
    logic [7:0] m_shadow[NREG];
    logic [7:0] m_active[NREG];
    bit         m_mask[NREG];
    bit         m_pending;
    bit         m_err;
    bit         m_done;
    logic [7:0] m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [PW-1:0] actual,
                               input logic [PW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic logic [PW-1:0] modelBank();
        logic [PW-1:0] r;
        for (int k = 0; k < NREG; k++) r[8*k +: 8] = m_active[k];
        return r;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NREG; k++) begin
            m_shadow[k] = 8'h00;
            m_active[k] = 8'h00;
            m_mask[k]   = 1'b0;
        end
        m_pending = 1'b0;
        m_err     = 1'b0;
        m_done    = 1'b0;
        m_cnt     = 8'h00;
    endtask

    // What one clock edge does to the bank, given the inputs seen at it
    task automatic modelEdge(input bit upd, input int ix, input int d,
                             input bit pc, input bit fs);
        bit      do_commit;
        commit_t e;
        do_commit = 1'b0;
`ifdef PARAM_BANK_FRAME_SYNC_EN
        if (m_pending && fs) do_commit = 1'b1;
        else if (!m_pending && pc) m_pending = 1'b1;
`else
        if (pc) do_commit = 1'b1;
`endif
        if (do_commit) begin
            for (int k = 0; k < NREG; k++) begin
                if (m_mask[k]) m_active[k] = m_shadow[k];
                m_mask[k] = 1'b0;
            end
            m_pending = 1'b0;
            m_cnt     = m_cnt + 8'd1;
            e.bank    = modelBank();
            e.cnt     = m_cnt;
            exp_q.push_back(e);
        end
        m_done = do_commit;
        if (upd) begin
            if (ix < NREG) begin
                m_shadow[ix] = d[7:0];
                m_mask[ix]   = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model
    task automatic applyStimulus(input bit upd, input int ix, input int d,
                                 input bit pc, input bit fs);
        @(negedge clk);
        #1;
        update_reg  = upd;
        idx         = ix[IW-1:0];
        read_data   = d[7:0];
        pc_ready    = pc;
        frame_start = fs;
        @(posedge clk);
        #1;
        modelEdge(upd, ix, d, pc, fs);
        update_reg  = 1'b0;
        idx         = '0;
        read_data   = 8'h00;
        pc_ready    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic pulseReset();
        #1;
        reset = 1'b1;
        modelReset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compare visible outputs against the model and pop the
    // scoreboard whenever the DUT announces a commit
    initial begin
        commit_t e;
        forever begin
            @(negedge clk);
            checkOutput("params", params, modelBank());
            checkOutput("commit_pending", PW'(commit_pending), PW'(m_pending));
            checkOutput("commit_done", PW'(commit_done), PW'(m_done));
            checkOutput("commit_cnt", PW'(commit_cnt), PW'(m_cnt));
            checkOutput("idx_err", PW'(idx_err), PW'(m_err));
            if (commit_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_commit at %0t: commit_done=1 required no commit", $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("commit_bank", params, e.bank);
                    checkOutput("commit_count", PW'(commit_cnt), PW'(e.cnt));
                end
            end
        end
    end

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        idleCycles(2);

        $display("[TB] reset while a packet is pending");
        applyStimulus(1, IDX_ROT_X, 8'h5A, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        idleCycles(2);
        pulseReset();
        applyStimulus(0, 0, 0, 0, 1);
        idleCycles(3);

        $display("[TB] basic commit");
        applyStimulus(1, IDX_MODE, 8'h11, 0, 0);
        applyStimulus(1, IDX_ROT_X, 8'h22, 0, 0);
        applyStimulus(1, IDX_ROT_Y, 8'h33, 0, 0);
        applyStimulus(1, IDX_CTRL, 8'h44, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        idleCycles(100);
        applyStimulus(0, 0, 0, 0, 1);
        idleCycles(3);

        $display("[TB] partial update");
        applyStimulus(1, IDX_ROT_X, 8'h99, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        idleCycles(3);
        applyStimulus(0, 0, 0, 0, 1);
        idleCycles(3);

        $display("[TB] write colliding with frame_start");
        applyStimulus(0, 0, 0, 1, 0);
        idleCycles(2);
        applyStimulus(1, IDX_ROT_Y, 8'h77, 0, 1);
        idleCycles(2);
        applyStimulus(0, 0, 0, 1, 0);
        idleCycles(1);
        applyStimulus(0, 0, 0, 0, 1);
        idleCycles(2);

        $display("[TB] pc_ready with frame_start, absorbed pc_ready, empty commit");
        applyStimulus(0, 0, 0, 1, 1);
        idleCycles(1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        idleCycles(2);

        $display("[TB] out-of-range index");
        applyStimulus(1, 60, 8'hFF, 0, 0);
        idleCycles(2);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, NREG, 8'hEE, 0, 0);
        idleCycles(2);

        $display("[TB] commit counter wrap");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, $urandom_range(0, NREG - 1), $urandom_range(0, 255), 1, 0);
            applyStimulus(0, 0, 0, 0, 1);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1),
                          $urandom_range(0, NREG + 3),
                          $urandom_range(0, 255),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0));
        end
        idleCycles(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL commits_outstanding: %0d commits never signalled, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
